// File: rtl/risc_controller.sv
// risc_controller: eight-phase VeriRISC instruction sequencer (opcode + zero -> control strobes).
// Latency: strobes are a combinational decode of (phase, opcode, zero); phase advances once per clock.
// Backpressure: none; the sequencer free-runs and external logic gates the clock to stall it.
//
// Ports:
//   clk_i       rising-edge clock
//   rst_i       asynchronous active-high reset, forces phase 0
//   opcode_i    opcode from the instruction register (same encoding as alu)
//   zero_i      a_is_zero from alu, only looked at in the ALU_OP phase
//   phase_o     current phase 0..7
//   sel_o       memory address source: 1 = PC, 0 = IR operand
//   rd_o/wr_o   memory read / write strobes
//   ld_ir_o     instruction register load
//   halt_o      halt indication
//   inc_pc_o    PC increment
//   ld_ac_o     accumulator load
//   ld_pc_o     PC load from IR operand
//   data_e_o    drive accumulator onto the data bus
//
// Build option RISC_CTRL_HALT_HOLD_EN: when defined, HLT freezes the sequencer in
// phase 4 with halt held high until reset; otherwise halt is a one-cycle pulse.
// OPCODE_WIDTH must stay 3 (matches the 8-bit alu); other values are unsupported.

module risc_controller #(
    parameter int OPCODE_WIDTH = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [OPCODE_WIDTH-1:0] opcode_i,
    input  logic                    zero_i,
    output logic [2:0]              phase_o,
    output logic                    sel_o,
    output logic                    rd_o,
    output logic                    ld_ir_o,
    output logic                    halt_o,
    output logic                    inc_pc_o,
    output logic                    ld_ac_o,
    output logic                    ld_pc_o,
    output logic                    wr_o,
    output logic                    data_e_o
);

    typedef enum logic [2:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_e;

    localparam logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'(3'b000);
    localparam logic [OPCODE_WIDTH-1:0] OP_SKZ = OPCODE_WIDTH'(3'b001);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(3'b010);
    localparam logic [OPCODE_WIDTH-1:0] OP_AND = OPCODE_WIDTH'(3'b011);
    localparam logic [OPCODE_WIDTH-1:0] OP_XOR = OPCODE_WIDTH'(3'b100);
    localparam logic [OPCODE_WIDTH-1:0] OP_LDA = OPCODE_WIDTH'(3'b101);
    localparam logic [OPCODE_WIDTH-1:0] OP_STO = OPCODE_WIDTH'(3'b110);
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP = OPCODE_WIDTH'(3'b111);

    phase_e phase_q, phase_d;

    logic is_hlt, is_skz, is_aluop, is_sto, is_jmp;

    assign is_hlt   = (opcode_i == OP_HLT);
    assign is_skz   = (opcode_i == OP_SKZ);
    assign is_sto   = (opcode_i == OP_STO);
    assign is_jmp   = (opcode_i == OP_JMP);
    // Opcodes whose result lands in the accumulator, so the operand must be read.
    assign is_aluop = (opcode_i == OP_ADD) || (opcode_i == OP_AND) ||
                      (opcode_i == OP_XOR) || (opcode_i == OP_LDA);

    assign phase_o = phase_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phase_q <= PH_INST_ADDR;
        end else begin
            phase_q <= phase_d;
        end
    end

`ifdef RISC_CTRL_HALT_HOLD_EN
    // Set on the first cycle of a frozen HLT so the PC increments only once.
    logic entered_q, entered_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            entered_q <= 1'b0;
        end else begin
            entered_q <= entered_d;
        end
    end
`endif

    always_comb begin
        phase_d  = phase_e'(phase_q + 3'd1);  // 7 wraps to 0
`ifdef RISC_CTRL_HALT_HOLD_EN
        entered_d = entered_q;
`endif
        sel_o    = 1'b0;
        rd_o     = 1'b0;
        ld_ir_o  = 1'b0;
        halt_o   = 1'b0;
        inc_pc_o = 1'b0;
        ld_ac_o  = 1'b0;
        ld_pc_o  = 1'b0;
        wr_o     = 1'b0;
        data_e_o = 1'b0;

        case (phase_q)
            PH_INST_ADDR: begin
                sel_o = 1'b1;
            end
            PH_INST_FETCH: begin
                sel_o = 1'b1;
                rd_o  = 1'b1;
            end
            PH_INST_LOAD, PH_IDLE: begin
                sel_o   = 1'b1;
                rd_o    = 1'b1;
                ld_ir_o = 1'b1;
            end
            PH_OP_ADDR: begin
                halt_o = is_hlt;
`ifdef RISC_CTRL_HALT_HOLD_EN
                inc_pc_o = !entered_q;
                if (is_hlt) begin
                    phase_d   = phase_q;
                    entered_d = 1'b1;
                end
`else
                inc_pc_o = 1'b1;
`endif
            end
            PH_OP_FETCH: begin
                rd_o = is_aluop;
            end
            PH_ALU_OP: begin
                rd_o     = is_aluop;
                inc_pc_o = is_skz && zero_i;  // the skip: second PC increment
                ld_pc_o  = is_jmp;
                data_e_o = is_sto;
            end
            PH_STORE: begin
                rd_o     = is_aluop;
                ld_ac_o  = is_aluop;
                ld_pc_o  = is_jmp;
                data_e_o = is_sto;
                wr_o     = is_sto;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_risc_controller.sv
// tb_risc_controller: directed, table-driven check of the risc_controller phase decode.
// Latency: compares outputs 1 time unit after inputs change, mid low clock phase.
// Backpressure: not applicable.

module tb_risc_controller;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [2:0] opcode_i;
    logic       zero_i;
    logic [2:0] phase_o;
    logic       sel_o, rd_o, ld_ir_o, halt_o, inc_pc_o, ld_ac_o, ld_pc_o, wr_o, data_e_o;

    // Strobe bundle order: sel rd ld_ir halt inc_pc ld_ac ld_pc wr data_e
    logic [8:0] strobes;
    assign strobes = {sel_o, rd_o, ld_ir_o, halt_o, inc_pc_o, ld_ac_o, ld_pc_o, wr_o, data_e_o};

    risc_controller #(.OPCODE_WIDTH(3)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .opcode_i (opcode_i),
        .zero_i   (zero_i),
        .phase_o  (phase_o),
        .sel_o    (sel_o),
        .rd_o     (rd_o),
        .ld_ir_o  (ld_ir_o),
        .halt_o   (halt_o),
        .inc_pc_o (inc_pc_o),
        .ld_ac_o  (ld_ac_o),
        .ld_pc_o  (ld_pc_o),
        .wr_o     (wr_o),
        .data_e_o (data_e_o)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [8:0] P0    = 9'b100000000;
    localparam logic [8:0] P1    = 9'b110000000;
    localparam logic [8:0] P23   = 9'b111000000;
    localparam logic [8:0] P4    = 9'b000010000;
    localparam logic [8:0] P4H   = 9'b000110000;
    localparam logic [8:0] HOLDH = 9'b000100000;
    localparam logic [8:0] NONE  = 9'b000000000;
    localparam logic [8:0] RD    = 9'b010000000;
    localparam logic [8:0] RDAC  = 9'b010001000;
    localparam logic [8:0] INC   = 9'b000010000;
    localparam logic [8:0] LDPC  = 9'b000000100;
    localparam logic [8:0] DE    = 9'b000000001;
    localparam logic [8:0] ST    = 9'b000000011;

    typedef struct {
        logic [2:0] op;
        logic       z;
        logic [2:0] ph;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[$];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int idx, input logic [8:0] got, input logic [8:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s idx=%0d got=%b want=%b", name, idx, got, want);
        end
    endtask

    task automatic add_instr(input logic [2:0] op, input logic z,
                             input logic [8:0] e0, input logic [8:0] e1, input logic [8:0] e2,
                             input logic [8:0] e3, input logic [8:0] e4, input logic [8:0] e5,
                             input logic [8:0] e6, input logic [8:0] e7);
        logic [8:0] e [8];
        vec_t v;
        e = '{e0, e1, e2, e3, e4, e5, e6, e7};
        for (int p = 0; p < 8; p++) begin
            v.op  = op;
            v.z   = z;
            v.ph  = 3'(p);
            v.exp = e[p];
            vecs.push_back(v);
        end
    endtask

    initial begin
        // opcode, zero, expected strobes for phases 0..7
        add_instr(3'b101, 1'b0, P0, P1, P23, P23, P4,  RD,   RD,   RDAC);  // LDA
        add_instr(3'b010, 1'b1, P0, P1, P23, P23, P4,  RD,   RD,   RDAC);  // ADD, zero ignored
        add_instr(3'b001, 1'b1, P0, P1, P23, P23, P4,  NONE, INC,  NONE);  // SKZ taken
        add_instr(3'b001, 1'b0, P0, P1, P23, P23, P4,  NONE, NONE, NONE);  // SKZ not taken
        add_instr(3'b110, 1'b0, P0, P1, P23, P23, P4,  NONE, DE,   ST);    // STO
        add_instr(3'b111, 1'b1, P0, P1, P23, P23, P4,  NONE, LDPC, LDPC);  // JMP, zero=1
`ifndef RISC_CTRL_HALT_HOLD_EN
        add_instr(3'b000, 1'b0, P0, P1, P23, P23, P4H, NONE, NONE, NONE);  // HLT pulse
`endif
        add_instr(3'b100, 1'b0, P0, P1, P23, P23, P4,  RD,   RD,   RDAC);  // XOR
        add_instr(3'b011, 1'b1, P0, P1, P23, P23, P4,  RD,   RD,   RDAC);  // AND

        // Reset state
        rst_i    = 1'b1;
        opcode_i = 3'b101;
        zero_i   = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        check("reset_phase", -1, {6'd0, phase_o}, 9'd0);
        check("reset_strobes", -1, strobes, P0);
        rst_i = 1'b0;

        // Table: one vector per clock, phase sequence continues across instructions
        foreach (vecs[i]) begin
            opcode_i = vecs[i].op;
            zero_i   = vecs[i].z;
            #1;
            check("phase", i, {6'd0, phase_o}, {6'd0, vecs[i].ph});
            check("strobes", i, strobes, vecs[i].exp);
            @(negedge clk_i);
        end

        // Wrap back to phase 0 after the last instruction
        #1;
        check("wrap_phase", -2, {6'd0, phase_o}, 9'd0);

        // Asynchronous reset in the middle of phase 5 of an LDA
        opcode_i = 3'b101;
        zero_i   = 1'b0;
        repeat (5) @(negedge clk_i);
        #1;
        check("lda_p5_phase", -3, {6'd0, phase_o}, 9'd5);
        check("lda_p5_strobes", -3, strobes, RD);
        rst_i = 1'b1;
        #1;
        check("async_rst_phase", -3, {6'd0, phase_o}, 9'd0);
        check("async_rst_strobes", -3, strobes, P0);
        @(negedge clk_i);
        #1;
        check("rst_held_phase", -3, {6'd0, phase_o}, 9'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        #1;
        check("rst_release_phase", -3, {6'd0, phase_o}, 9'd1);
        check("rst_release_strobes", -3, strobes, P1);

`ifdef RISC_CTRL_HALT_HOLD_EN
        // HLT freeze: from phase 1 reach phase 4, then hold
        opcode_i = 3'b000;
        repeat (3) @(negedge clk_i);
        #1;
        check("hlt_entry_phase", -4, {6'd0, phase_o}, 9'd4);
        check("hlt_entry_strobes", -4, strobes, P4H);
        for (int k = 0; k < 11; k++) begin
            @(negedge clk_i);
            #1;
            check("hlt_hold_phase", k, {6'd0, phase_o}, 9'd4);
            check("hlt_hold_strobes", k, strobes, HOLDH);
        end
        rst_i = 1'b1;
        #1;
        check("hlt_rst_phase", -4, {6'd0, phase_o}, 9'd0);
        check("hlt_rst_strobes", -4, strobes, P0);
        @(negedge clk_i);
        rst_i    = 1'b0;
        opcode_i = 3'b101;
        repeat (4) @(negedge clk_i);
        #1;
        check("post_hlt_p4", -4, strobes, P4);
`else
        // Without the hold option HLT keeps cycling: run a second HLT and watch 7 -> 0
        opcode_i = 3'b000;
        repeat (3) @(negedge clk_i);
        #1;
        check("hlt_p4_strobes", -4, strobes, P4H);
        @(negedge clk_i);
        #1;
        check("hlt_p5_strobes", -4, strobes, NONE);
        repeat (2) @(negedge clk_i);
        #1;
        check("hlt_p7_phase", -4, {6'd0, phase_o}, 9'd7);
        @(negedge clk_i);
        #1;
        check("hlt_wrap_phase", -4, {6'd0, phase_o}, 9'd0);
        check("hlt_wrap_strobes", -4, strobes, P0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
